// File: rtl/sopc_keys_in.sv
// Avalon-MM input port for board keys/switches: two-flop synchroniser, per-bit
// debounce, edge capture with write-1-to-clear, and a masked level interrupt.
module sopc_keys_in #(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter int unsigned      EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned      CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] db_q, db_d;
  logic [WIDTH-1:0] db_prev_q;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  logic             wr;
  logic [WIDTH-1:0] rise, fall, edge_sel, clr_mask;

  assign wr = chipselect & ~write_n;

  // Each bit debounces independently; any return to the accepted level restarts its count.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    rise = db_q & ~db_prev_q;
    fall = ~db_q & db_prev_q;
    case (EDGE_TYPE)
      0:       edge_sel = rise;
      1:       edge_sel = fall;
      default: edge_sel = rise | fall;
    endcase
  end

  // A fresh edge overrides a simultaneous clear so no event is lost.
  always_comb begin
    irqmask_d = irqmask_q;
    clr_mask  = '0;
    if (wr && address == ADDR_IRQMASK) irqmask_d = writedata[WIDTH-1:0];
    if (wr && address == ADDR_EDGECAP) clr_mask  = writedata[WIDTH-1:0];
    edgecap_d = (edgecap_q & ~clr_mask) | edge_sel;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= RESET_VALUE;
      sync2_q   <= RESET_VALUE;
      db_q      <= RESET_VALUE;
      db_prev_q <= RESET_VALUE;
      irqmask_q <= '0;
      edgecap_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= in_port;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = db_q;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
      default:      readdata = '0;
    endcase
  end

  assign irq = |(edgecap_q & irqmask_q);

  generate
    if (WIDTH < 32) begin : g_unused_wdata
      logic unused_wdata;
      assign unused_wdata = &{1'b0, writedata[31:WIDTH]};
    end
  endgenerate

endmodule

// File: tb/tb_sopc_keys_in.sv
// Bench for sopc_keys_in: one falling-edge instance and one any-edge instance on a
// shared bus, DEBOUNCE_CYCLES = 4, expected values queued ahead of each observation.
module tb_sopc_keys_in;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata_a, readdata_b;
  logic        irq_a, irq_b;

  logic [31:0] exp_q[$];
  int          n_cmp;
  int          n_fail;

  sopc_keys_in #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .RESET_VALUE(4'hF)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_a), .irq(irq_a)
  );

  sopc_keys_in #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .RESET_VALUE(4'hF)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_b), .irq(irq_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic [1:0] a);
    address = a;
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic test_reset();
    logic [31:0] got, exp;
    exp_q.push_back(32'hF); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'hF); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'hF);
    reset_n = 1'b0;
    in_port = 4'hF;
    tick(3);
    set_addr(2'd0); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_data_in_reset: got %h exp %h", got, exp); end
    set_addr(2'd3); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_ec_in_reset: got %h exp %h", got, exp); end
    got = {31'b0, irq_a}; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_irq_in_reset: got %h exp %h", got, exp); end
    reset_n = 1'b1;
    tick(8);
    set_addr(2'd0); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_data_after: got %h exp %h", got, exp); end
    set_addr(2'd3); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_ec_after: got %h exp %h", got, exp); end
    got = {31'b0, irq_a}; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_irq_after: got %h exp %h", got, exp); end
    set_addr(2'd0); got = readdata_b; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_data_any: got %h exp %h", got, exp); end
  endtask

  task automatic test_regmap();
    logic [31:0] got, exp;
    exp_q.push_back(32'hF); exp_q.push_back(32'h0); exp_q.push_back(32'h3); exp_q.push_back(32'h0);
    bus_write(2'd0, 32'h0);
    set_addr(2'd0); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL regmap_data_ro: got %h exp %h", got, exp); end
    bus_write(2'd2, 32'hFFFF_FFFF);
    set_addr(2'd2); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL regmap_reserved: got %h exp %h", got, exp); end
    bus_write(2'd1, 32'hFFFF_FFF3);
    set_addr(2'd1); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL regmap_irqmask_width: got %h exp %h", got, exp); end
    bus_write(2'd1, 32'h0);
    set_addr(2'd1); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL regmap_irqmask_zero: got %h exp %h", got, exp); end
  endtask

  task automatic test_fall_bit0();
    logic [31:0] got, exp;
    exp_q.push_back(32'hF); exp_q.push_back(32'hE); exp_q.push_back(32'h0);
    exp_q.push_back(32'h1); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'hF); exp_q.push_back(32'h0);
    in_port = 4'hE;
    tick(5);
    set_addr(2'd0); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL fall0_data_e4: got %h exp %h", got, exp); end
    tick(1);
    set_addr(2'd0); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL fall0_data_e5: got %h exp %h", got, exp); end
    set_addr(2'd3); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL fall0_ec_e5: got %h exp %h", got, exp); end
    tick(1);
    set_addr(2'd3); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL fall0_ec_e6: got %h exp %h", got, exp); end
    got = {31'b0, irq_a}; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL fall0_irq_masked: got %h exp %h", got, exp); end
    bus_write(2'd3, 32'h1);
    set_addr(2'd3); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL fall0_ec_cleared: got %h exp %h", got, exp); end
    in_port = 4'hF;
    tick(10);
    set_addr(2'd0); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL fall0_data_release: got %h exp %h", got, exp); end
    set_addr(2'd3); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL fall0_rise_ignored: got %h exp %h", got, exp); end
  endtask

  task automatic test_glitch();
    logic [31:0] got, exp;
    exp_q.push_back(32'hF); exp_q.push_back(32'h0); exp_q.push_back(32'hD);
    exp_q.push_back(32'hF); exp_q.push_back(32'h2); exp_q.push_back(32'h0);
    in_port = 4'hD;
    tick(3);
    in_port = 4'hF;
    tick(10);
    set_addr(2'd0); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL glitch3_data: got %h exp %h", got, exp); end
    set_addr(2'd3); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL glitch3_ec: got %h exp %h", got, exp); end
    in_port = 4'hD;
    tick(4);
    in_port = 4'hF;
    tick(2);
    set_addr(2'd0); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL glitch4_data_low: got %h exp %h", got, exp); end
    tick(12);
    set_addr(2'd0); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL glitch4_data_back: got %h exp %h", got, exp); end
    set_addr(2'd3); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL glitch4_one_capture: got %h exp %h", got, exp); end
    bus_write(2'd3, 32'h2);
    set_addr(2'd3); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL glitch4_ec_cleared: got %h exp %h", got, exp); end
  endtask

  task automatic test_irq();
    logic [31:0] got, exp;
    exp_q.push_back(32'h3); exp_q.push_back(32'h0); exp_q.push_back(32'h1); exp_q.push_back(32'h2);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    bus_write(2'd1, 32'h3);
    set_addr(2'd1); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL irq_mask_readback: got %h exp %h", got, exp); end
    in_port = 4'hD;
    tick(6);
    got = {31'b0, irq_a}; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL irq_before_capture: got %h exp %h", got, exp); end
    tick(1);
    got = {31'b0, irq_a}; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL irq_after_capture: got %h exp %h", got, exp); end
    set_addr(2'd3); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL irq_ec_bit1: got %h exp %h", got, exp); end
    bus_write(2'd3, 32'h2);
    got = {31'b0, irq_a}; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL irq_after_clear: got %h exp %h", got, exp); end
    set_addr(2'd3); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL irq_ec_after_clear: got %h exp %h", got, exp); end
    in_port = 4'hF;
    tick(12);
    got = {31'b0, irq_a}; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL irq_after_release: got %h exp %h", got, exp); end
    bus_write(2'd1, 32'h0);
  endtask

  task automatic test_coincide();
    logic [31:0] got, exp;
    exp_q.push_back(32'hB); exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h0);
    in_port = 4'hB;
    tick(6);
    set_addr(2'd0); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL coincide_data_e5: got %h exp %h", got, exp); end
    set_addr(2'd3); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL coincide_ec_e5: got %h exp %h", got, exp); end
    bus_write(2'd3, 32'h4);
    set_addr(2'd3); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL coincide_set_wins: got %h exp %h", got, exp); end
    bus_write(2'd3, 32'h4);
    set_addr(2'd3); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL coincide_second_clear: got %h exp %h", got, exp); end
    in_port = 4'hF;
    tick(12);
    bus_write(2'd3, 32'hF);
  endtask

  task automatic test_reset_mid();
    logic [31:0] got, exp;
    exp_q.push_back(32'h0); exp_q.push_back(32'hF); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(32'hF);
    in_port = 4'h7;
    tick(4);
    reset_n = 1'b0;
    in_port = 4'hF;
    tick(2);
    reset_n = 1'b1;
    tick(10);
    set_addr(2'd3); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL rstmid_ec: got %h exp %h", got, exp); end
    set_addr(2'd0); got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL rstmid_data: got %h exp %h", got, exp); end
    got = {31'b0, irq_a}; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL rstmid_irq: got %h exp %h", got, exp); end
    set_addr(2'd3); got = readdata_b; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL rstmid_ec_any: got %h exp %h", got, exp); end
    set_addr(2'd0); got = readdata_b; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL rstmid_data_any: got %h exp %h", got, exp); end
  endtask

  task automatic test_any_edge();
    logic [31:0] got, exp;
    exp_q.push_back(32'h8); exp_q.push_back(32'h8); exp_q.push_back(32'h1); exp_q.push_back(32'h0);
    exp_q.push_back(32'h8); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    bus_write(2'd1, 32'h8);
    in_port = 4'h7;
    tick(7);
    set_addr(2'd3); got = readdata_b; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL any_press_ec: got %h exp %h", got, exp); end
    got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL any_press_ec_fall_inst: got %h exp %h", got, exp); end
    got = {31'b0, irq_b}; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL any_press_irq: got %h exp %h", got, exp); end
    bus_write(2'd3, 32'h8);
    set_addr(2'd3); got = readdata_b; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL any_clear1: got %h exp %h", got, exp); end
    in_port = 4'hF;
    tick(7);
    set_addr(2'd3); got = readdata_b; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL any_release_ec: got %h exp %h", got, exp); end
    got = readdata_a; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL any_release_fall_inst: got %h exp %h", got, exp); end
    bus_write(2'd3, 32'h8);
    set_addr(2'd3); got = readdata_b; exp = exp_q.pop_front(); n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL any_clear2: got %h exp %h", got, exp); end
    bus_write(2'd1, 32'h0);
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;
    test_reset();
    test_regmap();
    test_fall_bit0();
    test_glitch();
    test_irq();
    test_coincide();
    test_reset_mid();
    test_any_edge();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries exp 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sopc_keys_in.md
Name: sopc_keys_in

Overview:
- Avalon-MM slave input port that is the read-side counterpart of the board output-port blocks (LED/drive enables).
- Samples asynchronous board inputs such as KEY push-buttons and DIP switches, synchronises and debounces them per bit, and captures edges.
- Raises an interrupt to the Nios II processor.
- Sits in the Qsys system on the same clk/reset as the other sopc_* peripherals.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles required before a bit change is accepted (1 ms at 50 MHz); must be >= 1.
- EDGE_TYPE, 1, edge capture mode: 0 = rising, 1 = falling, 2 = any.
- RESET_VALUE, 4'hF, reset value of synchroniser and debounced state (keys idle high).

Ports:
- clk  input  1  system clock
- reset_n  input  1  reset; asynchronous, active-low
- address  input  2  register select
- chipselect  input  1  Avalon slave select
- write_n  input  1  active-low write strobe
- writedata  input  32  write data
- in_port  input  WIDTH  raw asynchronous board inputs
- readdata  output  32  read data, combinational, read latency 0, no wait states
- irq  output  1  level interrupt, active-high

Behaviour:
- Reset is asynchronous, active-low on reset_n; clock is clk. While reset_n = 0:
  - sync1, sync2 and the debounced state db = RESET_VALUE.
  - Debounce counters, irqmask and edgecapture = 0.
  - db_prev = RESET_VALUE.
  - Outputs: irq = 0, readdata reflects the reset register contents.
- Synchroniser: two flops per bit, in_port -> sync1 -> sync2. No logic between them.
- Debounce, per bit, each with an independent counter of width clog2(DEBOUNCE_CYCLES), minimum 1:
  - If sync2 != db and cnt == DEBOUNCE_CYCLES-1: db <= sync2, cnt <= 0.
  - Else if sync2 != db: cnt <= cnt+1.
  - Else: cnt <= 0. Any glitch back to the old value restarts the count.
- Latency: if E0 is the first clk edge that samples the new pin value and the pin then stays stable, db changes at edge E0+1+DEBOUNCE_CYCLES.
- Edge detect: db_prev <= db every cycle.
  - rise = db & ~db_prev
  - fall = ~db & db_prev
  - EDGE_TYPE selects rise, fall, or rise|fall.
- Register map (write = chipselect & ~write_n):
  - addr 0 DATA: RO, readdata = {zeros, db}; writes are ignored.
  - addr 1 IRQMASK: RW, WIDTH bits; write loads writedata[WIDTH-1:0].
  - addr 2: reserved; reads 0, writes ignored.
  - addr 3 EDGECAPTURE: read returns bits. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
- Edgecapture bit update, per cycle:
  - A selected edge sets the bit.
  - A clear-write without an edge clears it.
  - If an edge and a clear-write hit the same bit in the same cycle, set wins and the bit stays 1.
- readdata bits above WIDTH are 0. readdata is valid combinationally whenever address is stable, independent of chipselect; read side effects are none.
- irq = |(edgecapture & irqmask), driven from registers only, glitch-free.
- Reset mid-debounce: the counter is discarded, db returns to RESET_VALUE, and no edge is captured on reset release unless db later changes through the debounce path.

Test Plan:
- Reset, in_port = 4'hF held: DATA reads 0x0000000F, EDGECAPTURE reads 0, irq = 0 throughout (DEBOUNCE_CYCLES = 4 for all tests).
- Drop in_port[0] to 0 at E0 and hold: DATA bit0 becomes 0 exactly at edge E0+5. EDGECAPTURE reads 0x1 one cycle later. irq stays 0 while IRQMASK = 0.
- Glitch in_port[1] low for 3 cycles then high: DATA unchanged at 0xF, EDGECAPTURE unchanged, counter restarts. Low for 4+ cycles then high produces exactly one falling capture.
- Write IRQMASK = 0x3, then fall on bit1: irq asserts the cycle after capture. Write EDGECAPTURE = 0x2: irq deasserts the next cycle and EDGECAPTURE reads 0.
- A capture edge on bit2 coincides with a write of 0x4 to EDGECAPTURE: bit2 reads 1 afterwards. A second write of 0x4 clears it.
- Assert reset_n = 0 mid-debounce (counter = 2), then release: no capture and DATA = 0xF. With EDGE_TYPE = 2, a full press/release of bit3 sets bit3 twice, clearing between presses.
